serial_adder: RTL and testbench

Parametrised multi-cycle adder/subtractor: the successor to the single-bit combinational full adder. It latches two WIDTH-bit operands on a start strobe and produces the sum in slices of BITS_PER_CYCLE bits, with the slice carry held in a register between cycles. It serves arithmetic datapaths that trade latency for area on the SP605 test designs, and reports completion with a one-cycle done pulse.

---
 rtl/serial_adder.sv | 158 +++++++++++++++
 tb/tb_serial_adder.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder: multi-cycle adder/subtractor that processes BITS_PER_CYCLE bits per clock.
//
// Purpose
//   Latches two WIDTH-bit operands on a start strobe and produces their sum (or difference)
//   over N = WIDTH/BITS_PER_CYCLE clocks. The slice carry is kept in a register between
//   slices. Completion is reported with a one-cycle done pulse. sum/cout (and ovf) change
//   only at completion and hold until the next completion.
//
// Parameters
//   WIDTH           operand/sum width, >= 1
//   BITS_PER_CYCLE  bits added per clock; must divide WIDTH exactly
//
// Ports
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   request a new operation (sampled only while idle)
//   sub    in   0 = add, 1 = subtract (latched with start)
//   a, b   in   operands (latched with start)
//   cin    in   carry-in / borrow-in (latched with start)
//   busy   out  operation in progress
//   done   out  one-cycle pulse when sum/cout are updated
//   sum    out  result register
//   cout   out  final carry out (for subtract, 1 = no borrow)
//   ovf    out  signed overflow; present only when SERIAL_ADDER_OVF_EN is defined
//
// Build option
//   SERIAL_ADDER_OVF_EN  adds the ovf port and its overflow register.

module serial_adder #(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned B    = BITS_PER_CYCLE;
  localparam int unsigned N    = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CntW = $clog2(N) + 1;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_q;
  logic             carry_q;
  logic [CntW-1:0]  cnt_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q;
`endif

  logic [B-1:0]     slice;
  logic             slice_cout;
  logic [WIDTH-1:0] acc_next;
  logic             last_slice;
  logic             accept;

  // Slice datapath
  always_comb begin
    {slice_cout, slice} = {1'b0, a_q[B-1:0]} + {1'b0, b_q[B-1:0]} + {{B{1'b0}}, carry_q};
    // New slice enters from the MSB side; after N slices the accumulator holds the full result.
    acc_next   = (acc_q >> B) | (WIDTH'(slice) << (WIDTH - B));
    last_slice = (cnt_q == CntW'(N - 1));
    accept     = (state_q == StIdle) && start;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start)      state_d = StRun;
      StRun:  if (last_slice) state_d = StIdle;
      default:                state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state_q == StRun);
  end

  // Operand shift registers, carry, slice counter and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        // Subtract as a + ~b + ~cin, so borrow-in maps onto the inverted carry.
        a_q     <= a;
        b_q     <= b ^ {WIDTH{sub}};
        carry_q <= cin ^ sub;
        cnt_q   <= '0;
      end else if (state_q == StRun) begin
        a_q     <= a_q >> B;
        b_q     <= b_q >> B;
        acc_q   <= acc_next;
        carry_q <= slice_cout;
        // Wrap to 0 on the final slice so the counter never exceeds N-1.
        cnt_q   <= last_slice ? '0 : cnt_q + CntW'(1);
        if (last_slice) begin
          sum_q  <= acc_next;
          cout_q <= slice_cout;
          done_q <= 1'b1;
`ifdef SERIAL_ADDER_OVF_EN
          // Carry into the MSB recovered as sum ^ a ^ b at that bit.
          ovf_q  <= slice[B-1] ^ a_q[B-1] ^ b_q[B-1] ^ slice_cout;
`endif
        end
      end
    end
  end

  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: two instances (1 and 4 bits per cycle) driven with identical
// stimulus and checked every cycle against an arithmetic reference and an edge-count model
// of acceptance/latency.

module tb_serial_adder;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       sub   = 1'b0;
  logic       cin   = 1'b0;
  logic [7:0] a     = '0;
  logic [7:0] b     = '0;

  logic [1:0] busy_w;
  logic [1:0] done_w;
  logic [1:0] cout_w;
  logic [7:0] sum_w [2];
`ifdef SERIAL_ADDER_OVF_EN
  logic [1:0] ovf_w;
`endif

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_dut_bpc1 (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .sub  (sub),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .busy (busy_w[0]),
    .done (done_w[0]),
    .sum  (sum_w[0]),
    .cout (cout_w[0])
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf  (ovf_w[0])
`endif
  );

  serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(4)) u_dut_bpc4 (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .sub  (sub),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .busy (busy_w[1]),
    .done (done_w[1]),
    .sum  (sum_w[1]),
    .cout (cout_w[1])
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf  (ovf_w[1])
`endif
  );

  // Model: per instance, slice count, edge index of the accepted start, pending and held
  // results packed as {ovf, cout, sum}.
  int         nslc   [2] = '{8, 2};
  int         s_edge [2] = '{-1, -1};
  logic [9:0] pend   [2] = '{10'd0, 10'd0};
  logic [9:0] held   [2] = '{10'd0, 10'd0};
  int         e_cnt = 0;
  int         n_cmp = 0;
  int         n_err = 0;

  function automatic logic [9:0] ref_op(input logic [7:0] x, input logic [7:0] y,
                                        input logic s, input logic c);
    int         r, sx, sy, sr;
    logic       co, ov;
    logic [7:0] sm;
    sx = (x >= 8'd128) ? int'(x) - 256 : int'(x);
    sy = (y >= 8'd128) ? int'(y) - 256 : int'(y);
    if (!s) begin
      r  = int'(x) + int'(y) + int'(c);
      co = (r > 255);
      sr = sx + sy + int'(c);
    end else begin
      r  = int'(x) - int'(y) - int'(c);
      co = (r >= 0);
      sr = sx - sy - int'(c);
    end
    sm = 8'(r & 255);
    ov = (sr > 127) || (sr < -128);
    return {ov, co, sm};
  endfunction

  task automatic check(input string tag, input int d, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s[dut%0d]: observed %0h, expected %0h", tag, d, obs, exp);
    end
  endtask

  task automatic check_dut(input int d);
    logic eb, ed;
    eb = (s_edge[d] >= 0) && (e_cnt < s_edge[d] + nslc[d]);
    ed = (s_edge[d] >= 0) && (e_cnt == s_edge[d] + nslc[d]);
    check("busy", d, 32'(busy_w[d]), 32'(eb));
    check("done", d, 32'(done_w[d]), 32'(ed));
    check("sum",  d, 32'(sum_w[d]),  32'(held[d][7:0]));
    check("cout", d, 32'(cout_w[d]), 32'(held[d][8]));
`ifdef SERIAL_ADDER_OVF_EN
    check("ovf",  d, 32'(ovf_w[d]),  32'(held[d][9]));
`endif
  endtask

  // Called at a falling edge: drive inputs, let one rising edge pass, update model, check.
  task automatic step(input logic st, input logic [7:0] x, input logic [7:0] y,
                      input logic s, input logic c);
    start = st;
    a     = x;
    b     = y;
    sub   = s;
    cin   = c;
    @(negedge clk);
    e_cnt++;
    for (int d = 0; d < 2; d++) begin
      if (s_edge[d] >= 0 && e_cnt == s_edge[d] + nslc[d]) held[d] = pend[d];
      if (st && !(s_edge[d] >= 0 && e_cnt - 1 < s_edge[d] + nslc[d])) begin
        s_edge[d] = e_cnt;
        pend[d]   = ref_op(x, y, s, c);
      end
      check_dut(d);
    end
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    end
  endtask

  // Assert reset between edges and check that outputs clear without waiting for a clock.
  task automatic async_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      s_edge[d] = -1;
      held[d]   = '0;
      check_dut(d);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) check_dut(d);
    rst_n = 1'b1;
    idle(2);

    // Add with wrap
    step(1'b1, 8'hFF, 8'h01, 1'b0, 1'b0);
    idle(9);

    // Subtract with and without borrow
    step(1'b1, 8'h05, 8'h07, 1'b1, 1'b0);
    idle(9);
    step(1'b1, 8'h07, 8'h05, 1'b1, 1'b0);
    idle(9);
    step(1'b1, 8'h07, 8'h05, 1'b1, 1'b1);
    idle(9);

    // Multi-bit slices; restart in the 4-bit instance's done cycle (1-bit instance is busy)
    step(1'b1, 8'h3C, 8'h4A, 1'b0, 1'b1);
    idle(2);
    step(1'b1, 8'h12, 8'h34, 1'b0, 1'b0);
    idle(9);

    // Start while busy is ignored
    step(1'b1, 8'h10, 8'h20, 1'b0, 1'b0);
    idle(1);
    step(1'b1, 8'hAA, 8'h55, 1'b1, 1'b1);
    idle(10);

    // Reset mid-operation, then a normal operation
    step(1'b1, 8'hC3, 8'h5A, 1'b0, 1'b1);
    idle(3);
    async_reset();
    idle(10);
    step(1'b1, 8'h21, 8'h43, 1'b0, 1'b0);
    idle(9);

    // Signed overflow cases
    step(1'b1, 8'h7F, 8'h01, 1'b0, 1'b0);
    idle(9);
    step(1'b1, 8'h80, 8'h01, 1'b1, 1'b0);
    idle(9);
    step(1'b1, 8'h01, 8'h01, 1'b0, 1'b0);
    idle(9);

    // Random traffic, including starts that land while busy
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) == 0), 8'($urandom), 8'($urandom), 1'($urandom),
           1'($urandom));
    end
    idle(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
